// File: rtl/box_muller_pkg.sv
// Shared types and fixed-point constants for the Box-Muller noise sequencer.
package box_muller_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRAW,
    LOOK,
    MUL,
    OUT0,
    OUT1
  } bm_state_e;

  localparam logic [31:0] LFSR_MASK = 32'h80200003;

  localparam int unsigned R_FRAC    = 28;
  localparam int unsigned TRIG_FRAC = 30;
  localparam int unsigned OUT_FRAC  = 11;
  // Q6.58 product; output keeps 5 integer and 11 fraction bits below the sign.
  localparam int unsigned PROD_LSB  = R_FRAC + TRIG_FRAC - OUT_FRAC;
  localparam int unsigned PROD_MSB  = 62;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'h0000_0000);
  endfunction

endpackage

// File: rtl/bm_lfsr32.sv
// Seedable 32-bit Galois LFSR (right shift); a zero seed is replaced by the default.
module bm_lfsr32
  import box_muller_pkg::*;
#(
  parameter logic [31:0] SEED_DEFAULT = 32'hACE12468
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [31:0] i_seed,
  input  logic        i_adv,
  output logic [31:0] o_state
);

  logic [31:0] r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SEED_DEFAULT;
    end else if (i_load) begin
      r_state <= (i_seed == 32'h0000_0000) ? SEED_DEFAULT : i_seed;
    end else if (i_adv) begin
      r_state <= lfsr_step(r_state);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/box_muller_seq.sv
// Box-Muller sequencer: draws (u1,u2), addresses the math LUTs and emits
// z0 = r*cos, z1 = r*sin through one shared multiplier on a valid/ready stream.
module box_muller_seq
  import box_muller_pkg::*;
#(
  parameter int unsigned LUT_AW       = 15,
  parameter int unsigned LUT_DW       = 32,
  parameter int unsigned OUT_W        = PROD_MSB - PROD_LSB + 1,
  parameter logic [31:0] SEED_DEFAULT = 32'hACE12468
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              seed_load,
  input  logic [31:0]       seed_val,
  output logic [LUT_AW-1:0] lut_addr_r,
  output logic [LUT_AW-1:0] lut_addr_th,
  input  logic [LUT_DW-1:0] lut_r,
  input  logic [LUT_DW-1:0] lut_cos,
  input  logic [LUT_DW-1:0] lut_sin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last,
  output logic [15:0]       pair_cnt,
  output logic              busy
);

  localparam int unsigned PROD_W = 2 * LUT_DW;

  bm_state_e r_state;
  bm_state_e w_state_nxt;

  logic [31:0]       w_lfsr;
  logic [LUT_AW-1:0] w_u1;
  logic [LUT_AW-1:0] w_u2;
  logic              w_lfsr_adv;
  logic              w_addr_ld;
  logic              w_lut_ld;
  logic              w_z0_ld;
  logic              w_z1_ld;
  logic              w_cnt_inc;

  logic [LUT_AW-1:0] r_lut_addr_r;
  logic [LUT_AW-1:0] r_lut_addr_th;
  logic [LUT_DW-1:0] r_lut_r;
  logic [LUT_DW-1:0] r_lut_cos;
  logic [LUT_DW-1:0] r_lut_sin;
  logic              r_out_valid;
  logic [OUT_W-1:0]  r_out_data;
  logic              r_out_last;
  logic [15:0]       r_pair_cnt;
  logic              r_busy;

  logic [LUT_DW-1:0]        w_trig;
  logic signed [PROD_W-1:0] w_prod;
  logic [OUT_W-1:0]         w_z;

  bm_lfsr32 #(
    .SEED_DEFAULT(SEED_DEFAULT)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .i_load (seed_load),
    .i_seed (seed_val),
    .i_adv  (w_lfsr_adv),
    .o_state(w_lfsr)
  );

  assign w_u1 = LUT_AW'(w_lfsr);
  assign w_u2 = LUT_AW'(w_lfsr >> 16);

  // Shared multiplier: cos while in MUL, sin while in OUT0; r is unsigned.
  assign w_trig = (r_state == MUL) ? r_lut_cos : r_lut_sin;
  assign w_prod = $signed({{LUT_DW{1'b0}}, r_lut_r}) *
                  $signed({{LUT_DW{w_trig[LUT_DW-1]}}, w_trig});
  assign w_z    = OUT_W'(w_prod >>> PROD_LSB);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lfsr_adv  = 1'b0;
    w_addr_ld   = 1'b0;
    w_lut_ld    = 1'b0;
    w_z0_ld     = 1'b0;
    w_z1_ld     = 1'b0;
    w_cnt_inc   = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) w_state_nxt = DRAW;
      end
      DRAW: begin
        w_lfsr_adv = 1'b1;
        if (w_u1 != '0) begin
          w_addr_ld   = 1'b1;
          w_state_nxt = LOOK;
        end
      end
      LOOK: begin
        w_lut_ld    = 1'b1;
        w_state_nxt = MUL;
      end
      MUL: begin
        w_z0_ld     = 1'b1;
        w_state_nxt = OUT0;
      end
      OUT0: begin
        if (out_ready) begin
          w_z1_ld     = 1'b1;
          w_state_nxt = OUT1;
        end
      end
      OUT1: begin
        if (out_ready) begin
          w_cnt_inc   = 1'b1;
          w_state_nxt = enable ? DRAW : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // Reseeding drops whatever pair is in flight.
    if (seed_load) begin
      w_lfsr_adv  = 1'b0;
      w_addr_ld   = 1'b0;
      w_lut_ld    = 1'b0;
      w_z0_ld     = 1'b0;
      w_z1_ld     = 1'b0;
      w_cnt_inc   = 1'b0;
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lut_addr_r  <= '0;
      r_lut_addr_th <= '0;
      r_lut_r       <= '0;
      r_lut_cos     <= '0;
      r_lut_sin     <= '0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_last    <= 1'b0;
      r_pair_cnt    <= 16'd0;
      r_busy        <= 1'b0;
    end else begin
      if (w_addr_ld) begin
        r_lut_addr_r  <= w_u1;
        r_lut_addr_th <= w_u2;
      end
      if (w_lut_ld) begin
        r_lut_r   <= lut_r;
        r_lut_cos <= lut_cos;
        r_lut_sin <= lut_sin;
      end
      if (w_z0_ld || w_z1_ld) r_out_data <= w_z;
      if (w_cnt_inc) r_pair_cnt <= r_pair_cnt + 16'd1;
      r_out_valid <= (w_state_nxt == OUT0) || (w_state_nxt == OUT1);
      r_out_last  <= (w_state_nxt == OUT1);
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  assign lut_addr_r  = r_lut_addr_r;
  assign lut_addr_th = r_lut_addr_th;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_last    = r_out_last;
  assign pair_cnt    = r_pair_cnt;
  assign busy        = r_busy;

endmodule

// File: tb/tb_box_muller_seq.sv
// Directed + randomized bench for box_muller_seq against a pair-level reference model.
module tb_box_muller_seq;

  localparam logic [31:0] SEED_DEF = 32'hACE12468;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        seed_load;
  logic [31:0] seed_val;
  logic [14:0] lut_addr_r;
  logic [14:0] lut_addr_th;
  logic [31:0] lut_r;
  logic [31:0] lut_cos;
  logic [31:0] lut_sin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic [15:0] pair_cnt;
  logic        busy;

  bit          lut_mode;
  logic [31:0] m_lfsr;
  logic [15:0] m_cnt;
  int          total = 0;
  int          bad = 0;

  box_muller_seq dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .seed_load  (seed_load),
    .seed_val   (seed_val),
    .lut_addr_r (lut_addr_r),
    .lut_addr_th(lut_addr_th),
    .lut_r      (lut_r),
    .lut_cos    (lut_cos),
    .lut_sin    (lut_sin),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .pair_cnt   (pair_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // LUT stand-ins: fixed 2.0 / 1.0 / -1.0, or address-dependent values with |r|<2, |trig|<=2.
  function automatic logic [31:0] f_r(input bit m, input logic [14:0] a);
    return m ? {3'b000, a, a[13:0]} : 32'h20000000;
  endfunction
  function automatic logic [31:0] f_cos(input bit m, input logic [14:0] a);
    return m ? {a, 2'b01, a} : 32'h40000000;
  endfunction
  function automatic logic [31:0] f_sin(input bit m, input logic [14:0] a);
    return m ? {~a, 2'b10, a} : 32'hC0000000;
  endfunction

  assign lut_r   = f_r(lut_mode, lut_addr_r);
  assign lut_cos = f_cos(lut_mode, lut_addr_th);
  assign lut_sin = f_sin(lut_mode, lut_addr_th);

  function automatic logic [31:0] ref_next(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 32'h80200003;
    return n;
  endfunction

  // z = floor(r * trig * 2^11) with r in Q4.28 and trig in Q2.30.
  function automatic logic [15:0] ref_z(input logic [31:0] r, input logic [31:0] t);
    longint p;
    p = longint'({32'h0, r}) * longint'($signed(t));
    return 16'(p >>> 47);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Entered at the negedge where the DUT sits in its first DRAW cycle of a pair.
  task automatic do_pair(input int stall, input bit en_after, input bit abort, input bit fixed);
    logic [14:0] u1, u2;
    logic [31:0] r, c, s;
    logic [15:0] z0, z1;
    int          k;
    k = 0;
    while (m_lfsr[14:0] == 15'd0 && k < 64) begin
      m_lfsr = ref_next(m_lfsr);
      k++;
    end
    u1     = m_lfsr[14:0];
    u2     = m_lfsr[30:16];
    m_lfsr = ref_next(m_lfsr);
    r  = f_r(lut_mode, u1);
    c  = f_cos(lut_mode, u2);
    s  = f_sin(lut_mode, u2);
    z0 = fixed ? 16'h1000 : ref_z(r, c);
    z1 = fixed ? 16'hF000 : ref_z(r, s);

    for (int i = 0; i <= k; i++) begin
      chk("draw_busy", busy, 1);
      chk("draw_valid", out_valid, 0);
      step();
    end
    chk("look_addr_r", lut_addr_r, u1);
    chk("look_addr_th", lut_addr_th, u2);
    chk("look_valid", out_valid, 0);
    step();
    chk("mul_valid", out_valid, 0);
    chk("lfsr_after_draw", dut.w_lfsr, m_lfsr);
    step();
    chk("z0_valid", out_valid, 1);
    chk("z0_last", out_last, 0);
    chk("z0_data", out_data, z0);

    if (abort) begin
      seed_load = 1'b1;
      seed_val  = 32'h0;
      enable    = 1'b0;
      step();
      seed_load = 1'b0;
      m_lfsr    = SEED_DEF;
      chk("abort_valid", out_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_cnt", pair_cnt, m_cnt);
      chk("abort_lfsr_default", dut.w_lfsr, m_lfsr);
      return;
    end

    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0;
      step();
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, z0);
      chk("stall_last", out_last, 0);
      chk("stall_lfsr", dut.w_lfsr, m_lfsr);
    end
    out_ready = 1'b1;
    enable    = en_after;
    step();
    chk("z1_valid", out_valid, 1);
    chk("z1_last", out_last, 1);
    chk("z1_data", out_data, z1);
    step();
    m_cnt = m_cnt + 16'd1;
    chk("pair_cnt", pair_cnt, m_cnt);
    chk("post_busy", busy, en_after);
    chk("post_valid", out_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sv;
    rst       = 1'b1;
    enable    = 1'b1;
    seed_load = 1'b0;
    seed_val  = 32'h0;
    out_ready = 1'b1;
    lut_mode  = 1'b0;
    m_cnt     = 16'd0;
    step();
    step();
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    chk("rst_addr_r", lut_addr_r, 0);
    chk("rst_addr_th", lut_addr_th, 0);
    chk("rst_cnt", pair_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lfsr", dut.w_lfsr, SEED_DEF);

    // First DRAW on the cycle after reset falls; fixed LUT values.
    rst    = 1'b0;
    m_lfsr = SEED_DEF;
    step();
    do_pair(0, 1'b0, 1'b0, 1'b1);

    // Zero-u1 rejection: low 15 bits stay zero for several draws.
    lut_mode  = 1'b1;
    seed_load = 1'b1;
    seed_val  = 32'h12340000;
    step();
    seed_load = 1'b0;
    m_lfsr    = 32'h12340000;
    chk("seed_loaded", dut.w_lfsr, m_lfsr);
    enable = 1'b1;
    step();
    do_pair(0, 1'b0, 1'b0, 1'b0);

    // Backpressure in OUT0.
    enable = 1'b1;
    step();
    do_pair(5, 1'b0, 1'b0, 1'b0);

    // Abort in OUT0 with a zero seed, then a clean pair from the default seed.
    enable = 1'b1;
    step();
    do_pair(0, 1'b0, 1'b1, 1'b0);
    enable = 1'b1;
    step();
    do_pair(0, 1'b0, 1'b0, 1'b0);

    // Random seeds and random stalls.
    for (int i = 0; i < 6; i++) begin
      sv = $urandom;
      if (i == 2) sv = 32'h0;
      seed_load = 1'b1;
      seed_val  = sv;
      step();
      seed_load = 1'b0;
      m_lfsr    = (sv == 32'h0) ? SEED_DEF : sv;
      enable    = 1'b1;
      step();
      do_pair(int'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0);
    end

    // Back-to-back streaming across the pair counter wrap.
    force dut.r_pair_cnt = 16'hFFFD;
    step();
    release dut.r_pair_cnt;
    m_cnt = 16'hFFFD;
    step();
    chk("preset_cnt", pair_cnt, m_cnt);
    enable = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      do_pair(0, (i < 4) ? 1'b1 : 1'b0, 1'b0, 1'b0);
    end
    chk("wrap_cnt", pair_cnt, 16'h0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
